// File: rtl/sha_round_sequencer.sv
// Control sequencer for one SHA-256 message block: initial hash load, message fetch,
// compression rounds, final add and digest write-back, with start/busy/done, stall and chaining.
module sha_round_sequencer #(
  parameter int IN_WORDS  = 16,
  parameter int ROUNDS    = 64,
  parameter int OUT_WORDS = 8,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 0,
  parameter int ADDR_W    = 4,
  parameter int ROUND_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               chain,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               init_en,
  output logic               in_mem_en,
  output logic [ADDR_W-1:0]  in_mem_addr,
  output logic               load_en,
  output logic               round_en,
  output logic [ROUND_W-1:0] k_num,
  output logic               add_en,
  output logic               out_mem_en,
  output logic [ADDR_W-1:0]  out_mem_addr
);

  localparam int MAX_IR  = (IN_WORDS > ROUNDS) ? IN_WORDS : ROUNDS;
  localparam int MAX_CNT = (MAX_IR > OUT_WORDS) ? MAX_IR : OUT_WORDS;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] IN_LAST    = CNT_W'(IN_WORDS - 1);
  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, LOAD, ROUND, ADD, WRITE, DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               busy_reg;
  logic               done_reg;
  logic               init_en_reg;
  logic               in_mem_en_reg;
  logic               load_en_reg;
  logic               round_en_reg;
  logic               add_en_reg;
  logic               out_mem_en_reg;
  logic [ADDR_W-1:0]  in_mem_addr_reg;
  logic [ROUND_W-1:0] k_num_reg;
  logic [ADDR_W-1:0]  out_mem_addr_reg;

  // Next-step decode; a held non-idle state simply repeats itself, so the step
  // executes exactly once after release.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == IDLE) begin
      if (start) begin
        state_next = chain ? LOAD : INIT;
        cnt_next   = '0;
      end
    end else if (!hold) begin
      unique case (state_reg)
        INIT: begin
          state_next = LOAD;
          cnt_next   = '0;
        end
        LOAD: begin
          if (cnt_reg == IN_LAST) begin
            state_next = ROUND;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ROUND: begin
          if (cnt_reg == ROUND_LAST) begin
            state_next = ADD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ADD: begin
          state_next = WRITE;
          cnt_next   = '0;
        end
        WRITE: begin
          if (cnt_reg == OUT_LAST) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the upcoming state; addresses and k_num only
  // move while their own phase is entered, otherwise they keep the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      init_en_reg      <= 1'b0;
      in_mem_en_reg    <= 1'b0;
      load_en_reg      <= 1'b0;
      round_en_reg     <= 1'b0;
      add_en_reg       <= 1'b0;
      out_mem_en_reg   <= 1'b0;
      in_mem_addr_reg  <= '0;
      k_num_reg        <= '0;
      out_mem_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      busy_reg       <= (state_next != IDLE);
      done_reg       <= (state_next == DONE);
      init_en_reg    <= (state_next == INIT);
      in_mem_en_reg  <= (state_next == LOAD);
      load_en_reg    <= (state_next == LOAD);
      round_en_reg   <= (state_next == ROUND);
      add_en_reg     <= (state_next == ADD);
      out_mem_en_reg <= (state_next == WRITE);
      if (state_next == LOAD) begin
        in_mem_addr_reg <= ADDR_W'(IN_BASE) + ADDR_W'(cnt_next);
      end
      if (state_next == ROUND) begin
        k_num_reg <= ROUND_W'(cnt_next);
      end
      if (state_next == WRITE) begin
        out_mem_addr_reg <= ADDR_W'(OUT_BASE) + ADDR_W'(cnt_next);
      end
    end
  end

  // A stall suppresses every strobe in the same cycle; busy and addresses are unaffected.
  assign busy         = busy_reg;
  assign done         = done_reg       & ~hold;
  assign init_en      = init_en_reg    & ~hold;
  assign in_mem_en    = in_mem_en_reg  & ~hold;
  assign load_en      = load_en_reg    & ~hold;
  assign round_en     = round_en_reg   & ~hold;
  assign add_en       = add_en_reg     & ~hold;
  assign out_mem_en   = out_mem_en_reg & ~hold;
  assign in_mem_addr  = in_mem_addr_reg;
  assign k_num        = k_num_reg;
  assign out_mem_addr = out_mem_addr_reg;

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Bench for sha_round_sequencer: default and a small alternate configuration driven with
// shared inputs and compared each cycle to a step-list reference model.
module tb_sha_round_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic chain = 1'b0;
  logic hold = 1'b0;

  logic       busy0, done0, init_en0, in_mem_en0, load_en0, round_en0, add_en0, out_mem_en0;
  logic [3:0] in_addr0, out_addr0;
  logic [5:0] k0;
  logic       busy1, done1, init_en1, in_mem_en1, load_en1, round_en1, add_en1, out_mem_en1;
  logic [3:0] in_addr1, out_addr1;
  logic [4:0] k1;

  always #5 clk = ~clk;

  sha_round_sequencer dut0 (
    .clk(clk), .reset(reset), .start(start), .chain(chain), .hold(hold),
    .busy(busy0), .done(done0), .init_en(init_en0), .in_mem_en(in_mem_en0),
    .in_mem_addr(in_addr0), .load_en(load_en0), .round_en(round_en0), .k_num(k0),
    .add_en(add_en0), .out_mem_en(out_mem_en0), .out_mem_addr(out_addr0)
  );

  sha_round_sequencer #(
    .IN_WORDS(8), .ROUNDS(19), .OUT_WORDS(8), .IN_BASE(1), .OUT_BASE(1),
    .ADDR_W(4), .ROUND_W(5)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .chain(chain), .hold(hold),
    .busy(busy1), .done(done1), .init_en(init_en1), .in_mem_en(in_mem_en1),
    .in_mem_addr(in_addr1), .load_en(load_en1), .round_en(round_en1), .k_num(k1),
    .add_en(add_en1), .out_mem_en(out_mem_en1), .out_mem_addr(out_addr1)
  );

  // Reference model: each block is an explicit list of steps walked one per unheld cycle.
  localparam int K_INIT = 1, K_LOAD = 2, K_ROUND = 3, K_ADD = 4, K_WRITE = 5, K_DONE = 6;
  int p_in[2]     = '{16, 8};
  int p_rounds[2] = '{64, 19};
  int p_out[2]    = '{8, 8};
  int p_ib[2]     = '{0, 1};
  int p_ob[2]     = '{0, 1};
  int seq_kind[2][128];
  int seq_idx[2][128];
  int pos[2] = '{-1, -1};
  int len[2] = '{0, 0};
  int m_ia[2] = '{0, 0};
  int m_k[2] = '{0, 0};
  int m_oa[2] = '{0, 0};

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc[2] = '{-1, -1};

  task automatic add_step(input int c, input int kind, input int idx);
    seq_kind[c][len[c]] = kind;
    seq_idx[c][len[c]]  = idx;
    len[c]++;
  endtask

  task automatic apply_addr(input int c);
    case (seq_kind[c][pos[c]])
      K_LOAD:  m_ia[c] = p_ib[c] + seq_idx[c][pos[c]];
      K_ROUND: m_k[c]  = seq_idx[c][pos[c]];
      K_WRITE: m_oa[c] = p_ob[c] + seq_idx[c][pos[c]];
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic s, input logic ch, input logic h, input logic r);
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        pos[c] = -1; m_ia[c] = 0; m_k[c] = 0; m_oa[c] = 0;
      end else if (pos[c] < 0) begin
        if (s) begin
          len[c] = 0;
          if (!ch) add_step(c, K_INIT, 0);
          for (int i = 0; i < p_in[c]; i++) add_step(c, K_LOAD, i);
          for (int i = 0; i < p_rounds[c]; i++) add_step(c, K_ROUND, i);
          add_step(c, K_ADD, 0);
          for (int i = 0; i < p_out[c]; i++) add_step(c, K_WRITE, i);
          add_step(c, K_DONE, 0);
          pos[c] = 0;
          apply_addr(c);
        end
      end else if (!h) begin
        pos[c]++;
        if (pos[c] == len[c]) pos[c] = -1;
        else apply_addr(c);
      end
    end
  endtask

  // Flags: busy, done, init, in_mem_en, load, round, add, out_mem_en; then in addr, k, out addr.
  function automatic logic [31:0] model_out(input int c, input logic h);
    logic [7:0] f;
    f = 8'h00;
    if (pos[c] >= 0) begin
      f[7] = 1'b1;
      if (!h) begin
        case (seq_kind[c][pos[c]])
          K_INIT:  f[5] = 1'b1;
          K_LOAD:  begin f[4] = 1'b1; f[3] = 1'b1; end
          K_ROUND: f[2] = 1'b1;
          K_ADD:   f[1] = 1'b1;
          K_WRITE: f[0] = 1'b1;
          K_DONE:  f[6] = 1'b1;
          default: ;
        endcase
      end
    end
    return {f, 8'(m_ia[c]), 8'(m_k[c]), 8'(m_oa[c])};
  endfunction

  // One clock cycle: model follows the edge, new inputs apply, outputs sampled mid-cycle.
  task automatic tick(input logic s, input logic ch, input logic h, input logic r,
                      output logic [31:0] o0, output logic [31:0] e0,
                      output logic [31:0] o1, output logic [31:0] e1);
    @(posedge clk);
    model_edge(start, chain, hold, reset);
    #1;
    start = s; chain = ch; hold = h; reset = r;
    cyc++;
    @(negedge clk);
    o0 = {busy0, done0, init_en0, in_mem_en0, load_en0, round_en0, add_en0, out_mem_en0,
          4'd0, in_addr0, 2'd0, k0, 4'd0, out_addr0};
    o1 = {busy1, done1, init_en1, in_mem_en1, load_en1, round_en1, add_en1, out_mem_en1,
          4'd0, in_addr1, 3'd0, k1, 4'd0, out_addr1};
    e0 = model_out(0, hold);
    e1 = model_out(1, hold);
    if (done0) done_cyc[0] = cyc;
    if (done1) done_cyc[1] = cyc;
  endtask

  logic [31:0] o0, e0, o1, e1;

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, (i < 2), o0, e0, o1, e1);
      checks += 2;
      if (o0 !== 32'h0 || o0 !== e0) begin fails++; $display("FAIL reset cfg0 got=%h exp=%h", o0, e0); end
      if (o1 !== 32'h0 || o1 !== e1) begin fails++; $display("FAIL reset cfg1 got=%h exp=%h", o1, e1); end
    end
  endtask

  task automatic test_block(input string name, input logic ch, input int d0, input int d1);
    cyc = -1; done_cyc = '{-1, -1};
    for (int i = 0; i <= 100; i++) begin
      tick((i == 0), ch, 1'b0, 1'b0, o0, e0, o1, e1);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL %s cfg0 cyc=%0d got=%h exp=%h", name, cyc, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL %s cfg1 cyc=%0d got=%h exp=%h", name, cyc, o1, e1); end
    end
    checks += 2;
    if (done_cyc[0] != d0) begin fails++; $display("FAIL %s_done cfg0 got=%0d exp=%0d", name, done_cyc[0], d0); end
    if (done_cyc[1] != d1) begin fails++; $display("FAIL %s_done cfg1 got=%0d exp=%0d", name, done_cyc[1], d1); end
  endtask

  task automatic test_hold;
    cyc = -1; done_cyc = '{-1, -1};
    for (int i = 0; i <= 100; i++) begin
      tick((i == 0), 1'b0, (i >= 28 && i <= 30), 1'b0, o0, e0, o1, e1);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL hold cfg0 cyc=%0d got=%h exp=%h", cyc, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL hold cfg1 cyc=%0d got=%h exp=%h", cyc, o1, e1); end
      if (i == 29 || i == 31 || i == 32) begin
        checks++;
        if (o0[26] !== (i != 29) || o0[15:8] !== ((i == 32) ? 8'd11 : 8'd10)) begin
          fails++; $display("FAIL hold_round cyc=%0d round_en=%b k=%0d", cyc, o0[26], o0[15:8]);
        end
      end
    end
    checks += 2;
    if (done_cyc[0] != 94) begin fails++; $display("FAIL hold_done cfg0 got=%0d exp=94", done_cyc[0]); end
    if (done_cyc[1] != 41) begin fails++; $display("FAIL hold_done cfg1 got=%0d exp=41", done_cyc[1]); end
  endtask

  task automatic test_back_to_back;
    int n0 = 0, n1 = 0;
    cyc = -1; done_cyc = '{-1, -1};
    for (int i = 0; i <= 190; i++) begin
      tick((i == 0 || i == 5 || i == 38 || i == 91 || i == 92), 1'b0, 1'b0, 1'b0, o0, e0, o1, e1);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL b2b cfg0 cyc=%0d got=%h exp=%h", cyc, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL b2b cfg1 cyc=%0d got=%h exp=%h", cyc, o1, e1); end
      if (o0[30] && i <= 92) n0++;
      if (o1[30]) n1++;
    end
    checks += 4;
    if (n0 != 1) begin fails++; $display("FAIL b2b_pulses cfg0 got=%0d exp=1", n0); end
    if (n1 != 2) begin fails++; $display("FAIL b2b_pulses cfg1 got=%0d exp=2", n1); end
    if (done_cyc[0] != 183) begin fails++; $display("FAIL b2b_done cfg0 got=%0d exp=183", done_cyc[0]); end
    if (done_cyc[1] != 129) begin fails++; $display("FAIL b2b_done cfg1 got=%0d exp=129", done_cyc[1]); end
  endtask

  task automatic test_reset_mid;
    cyc = -1; done_cyc = '{-1, -1};
    for (int i = 0; i <= 12; i++) begin
      tick((i == 0), 1'b0, 1'b0, (i == 10), o0, e0, o1, e1);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL reset_mid cfg0 cyc=%0d got=%h exp=%h", cyc, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL reset_mid cfg1 cyc=%0d got=%h exp=%h", cyc, o1, e1); end
      if (i == 11) begin
        checks++;
        if (o0 !== 32'h0 || o1 !== 32'h0) begin
          fails++; $display("FAIL reset_mid_zero got0=%h got1=%h exp=0", o0, o1);
        end
      end
    end
    checks++;
    if (done_cyc[0] != -1 || done_cyc[1] != -1) begin
      fails++; $display("FAIL reset_mid_nodone got0=%0d got1=%0d exp=-1", done_cyc[0], done_cyc[1]);
    end
    test_block("after_reset", 1'b0, 91, 38);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1200; i++) begin
      logic s, ch, h, r;
      s  = ($urandom_range(0, 7) == 0);
      ch = $urandom_range(0, 1);
      h  = (i < 1000) && ($urandom_range(0, 3) == 0);
      r  = (i < 1000) && ($urandom_range(0, 99) == 0);
      if (i >= 1000) s = 1'b0;
      tick(s, ch, h, r, o0, e0, o1, e1);
      checks += 2;
      if (o0 !== e0) begin fails++; $display("FAIL random cfg0 step=%0d got=%h exp=%h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL random cfg1 step=%0d got=%h exp=%h", i, o1, e1); end
    end
  endtask

  initial begin
    test_reset();
    test_block("basic", 1'b0, 91, 38);
    test_block("chain", 1'b1, 90, 37);
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sha_round_sequencer.md
Name: sha_round_sequencer

Overview:
Parametrised control sequencer for the SHA-256 hashing core. It steps one message block through these phases: initial-hash load, message-word fetch, compression rounds, final add, and digest write-back. It drives the input-memory address, round-constant index, and output-memory address/enables. It adds a start/busy/done handshake, a stall input, and multi-block chaining, none of which the previous free-running controller had.

Parameters:
IN_WORDS, 16, message words fetched per block
ROUNDS, 64, compression rounds per block
OUT_WORDS, 8, digest words written per block
IN_BASE, 0, first input-memory address
OUT_BASE, 0, first output-memory address
ADDR_W, 4, address width; must hold IN_BASE+IN_WORDS-1 and OUT_BASE+OUT_WORDS-1
ROUND_W, 6, round index width; must be at least ceil(log2(ROUNDS))

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to process one block; sampled only in IDLE
chain  in  1  sampled with start; 1 = continue from the current hash, so INIT is skipped
hold  in  1  stall; freezes the sequencer in every state except IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in the DONE state
init_en  out  1  load the initial hash constants H0..H7
in_mem_en  out  1  input-memory read enable
in_mem_addr  out  ADDR_W  input-memory read address
load_en  out  1  write the current message word into the schedule
round_en  out  1  execute one compression round
k_num  out  ROUND_W  current round index / K-constant index
add_en  out  1  add working variables into the hash registers
out_mem_en  out  1  output-memory write enable
out_mem_addr  out  ADDR_W  output-memory write address

Behaviour:
- Reset: the synchronous reset has priority over every other input. On the next rising edge with reset=1:
  - state becomes IDLE and all counters clear;
  - all outputs become 0: busy, done, every enable, in_mem_addr, k_num, out_mem_addr.
  - Reset mid-operation aborts the block; no done pulse is produced.
- States: IDLE, INIT, LOAD, ROUND, ADD, WRITE, DONE. One shared counter cnt is used, sized to max(IN_WORDS, ROUNDS, OUT_WORDS).
- IDLE:
  - start=1 with chain=0 moves to INIT; start=1 with chain=1 moves to LOAD.
  - hold is ignored in IDLE.
- INIT: one cycle, init_en=1, then LOAD with cnt=0.
- LOAD: IN_WORDS cycles.
  - in_mem_en=1, load_en=1, in_mem_addr=IN_BASE+cnt.
  - At cnt=IN_WORDS-1, moves to ROUND with cnt=0.
- ROUND: ROUNDS cycles.
  - round_en=1, k_num=cnt.
  - At cnt=ROUNDS-1, moves to ADD.
- ADD: one cycle, add_en=1, then WRITE with cnt=0.
- WRITE: OUT_WORDS cycles.
  - out_mem_en=1, out_mem_addr=OUT_BASE+cnt.
  - At cnt=OUT_WORDS-1, moves to DONE.
- DONE: one cycle, done=1, busy=1, then IDLE.
- Output holding:
  - Addresses and k_num are state/counter-decoded and hold their last value outside their own phase; they are not forced to 0.
  - Enables are 0 outside their own phase.
- Hold:
  - When hold=1 in any non-IDLE state, state and cnt do not advance, and every enable (init_en, in_mem_en, load_en, round_en, add_en, out_mem_en) and done are forced to 0 combinationally.
  - Addresses and k_num keep their values while held.
  - On release, the held step executes exactly once, so no step is lost or duplicated.
- Start while busy is ignored, including in the DONE cycle.
- Latency: start accepted at edge 0.
  - chain=0: INIT at cycle 1, LOAD 2..IN_WORDS+1, ROUND next ROUNDS cycles, ADD, WRITE OUT_WORDS cycles, then DONE.
  - Defaults with chain=0: done at cycle 91. With chain=1: done at cycle 90.
  - Each held cycle adds exactly 1 cycle of latency.
- Back-to-back operation: start asserted in the first IDLE cycle after DONE is accepted, so there is a 1-cycle minimum gap between blocks.
- Arithmetic: cnt wraps only through the explicit per-state clears. Address sums are truncated to ADDR_W; the parameter legality constraints above guarantee no truncation actually occurs.

Test Plan:
- Reset, then start=1, chain=0, hold=0 with defaults -> init_en at cycle 1; in_mem_addr 0..15 with in_mem_en over cycles 2..17; k_num 0..63 with round_en over cycles 18..81; add_en at 82; out_mem_addr 0..7 with out_mem_en over 83..90; done at 91; busy low at 92.
- start with chain=1 -> init_en never asserted; first in_mem_en at cycle 1; done at cycle 90.
- hold=1 for 3 cycles while k_num=10 -> k_num stays 10 and round_en=0 for those 3 cycles; round_en returns with k_num=10, then 11; done delayed to cycle 94.
- start pulsed during LOAD and again in the DONE cycle -> both ignored; exactly one done pulse; an IDLE start afterwards begins a new block.
- reset=1 at cycle 10 (mid LOAD) -> next cycle busy=0, all enables 0, in_mem_addr=0, k_num=0; no done; a following start runs a full block with correct timing.
- IN_BASE=1, OUT_BASE=1, IN_WORDS=8, ROUNDS=19, OUT_WORDS=8 -> in_mem_addr 1..8, k_num 0..18, out_mem_addr 1..8; done at cycle 1+8+19+1+8+1 = 38 with chain=0.
